mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multiply/divide unit for the pipelined MIPS core. It sits in the E stage and produces the HI/LO values that mfhi/mflo carry down to writeback. It executes mult, multu, div, divu over a fixed multi-cycle latency and mthi/mtlo in a single cycle. It exposes busy/active flags that the hazard unit uses to stall any later md-class instruction.

## Interface
- MULT_CYCLES, 5, busy duration of mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy duration of div/divu (must be ≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  E-stage instruction is a valid md instruction this cycle
- md_op  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- busy  out  1  a multi-cycle operation is in progress
- md_active  out  1  combinational: busy | (start & md_op ∈ {001..100})
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Reset values: busy=0, hi=0, lo=0, internal counter=0, pending result=0.
- Accept condition: start=1, busy=0, md_op valid. When busy=1, start and md_op are ignored entirely, including mthi/mtlo. The pipeline stalls these; the unit does not queue them.
- mult: {HI,LO} = $signed(A) * $signed(B), full 64-bit product.
- multu: {HI,LO} = A * B, unsigned, 64-bit.
- div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend. The case 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0.
- divu: LO = A / B, HI = A % B, unsigned.
- Divide by zero (B=0, div or divu): busy sequence runs normally; HI and LO keep their previous values at completion.
- mthi: hi ← A at the accepting edge. mtlo: lo ← A at the accepting edge. Neither asserts busy.
- At acceptance of a multi-cycle op:
  - The result is computed from A/B as sampled at that edge and held in a pending register.
  - The counter loads MULT_CYCLES or DIV_CYCLES.
  - busy ← 1.
- Two states:
  - IDLE (busy=0): goes to RUN on an accepted mult, multu, div or divu.
  - RUN (busy=1): counter decrements every edge. On the edge where counter==1, hi/lo are written from the pending register (unless divide by zero), busy ← 0, and the state returns to IDLE.
- hi/lo never change during RUN until the completion edge. mfhi/mflo issued while busy must be stalled upstream.
- md_op 000/111 with start=1: no effect.

## Timing
- Cycle 0: start and md_op are accepted. busy rises after the edge ending cycle 0.
- busy is high for exactly N cycles (cycles 1..N), where N = MULT_CYCLES or DIV_CYCLES.
- New hi/lo values are visible from cycle N+1. busy is low in that same cycle.
- A new op may be accepted in cycle N+1, so back-to-back ops give N+1 cycles per op.
- mthi/mtlo accepted in cycle 0 are visible on hi/lo in cycle 1.
- md_active is combinational. It is high in cycle 0 for multi-cycle ops and in cycles 1..N. It is not raised by mthi/mtlo.
- Reset asserted mid-RUN: busy, counter, hi, lo and the pending result clear immediately (asynchronously). The aborted result is never written.
- If reset deasserts with start=1, acceptance happens on the first rising edge after release.

## Test plan
- mult, A=0xFFFFFFFE, B=0x00000003 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu, same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles. A second multu started in the first non-busy cycle is accepted.
- div, A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 7/2 -> lo=3, hi=1.
- divu with B=0 after a prior hi=0x12345678, lo=0x9ABCDEF0 -> busy 10 cycles; hi/lo unchanged.
- mthi A=0xDEADBEEF, then mtlo A=0x0BADF00D in consecutive cycles -> hi/lo updated one cycle after each; busy stays 0 and md_active stays 0.
- Start a div, and in cycle 3 drive start with mtlo A=0x11111111 -> ignored; lo shows only the div result at completion.
- Start a mult, then assert reset in cycle 2 -> busy=0, hi=lo=0 immediately. After release, no stale result ever appears.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit for the E stage of the MIPS core.
// mult/multu/div/divu finish after a fixed latency. mthi/mtlo write in a single cycle.
// The hazard unit uses busy/md_active to stall any later md-class instruction.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset, clears all state
//   start     the E-stage instruction is a valid md instruction this cycle
//   md_op     001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; others do nothing
//   A, B      rs / rt operands (already forwarded)
//   busy      a multi-cycle operation is in progress
//   md_active busy, or a multi-cycle op is being presented this cycle (combinational)
//   hi, lo    architectural HI / LO registers
module mult_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        md_active,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OpMult  = 3'b001;
   localparam logic [2:0] OpMultu = 3'b010;
   localparam logic [2:0] OpDiv   = 3'b011;
   localparam logic [2:0] OpDivu  = 3'b100;
   localparam logic [2:0] OpMthi  = 3'b101;
   localparam logic [2:0] OpMtlo  = 3'b110;

   typedef enum logic {StIdle, StRun} state_e;

   state_e      state_q;
   logic [31:0] cnt_q;
   logic [63:0] pend_q;     // {hi, lo} waiting for the completion edge
   logic        pend_dz_q;  // divide by zero: leave hi/lo untouched at completion
   logic [31:0] hi_q, lo_q;

   // Arithmetic on the operands as presented this cycle
   logic signed [63:0] a_sx, b_sx, prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        abs_a, abs_b, sdiv_dvs, q_mag, r_mag, sdiv_q, sdiv_r;
   logic [31:0]        udiv_dvs, udiv_q, udiv_r;
   logic               b_zero, is_multi;

   always_comb begin
      a_sx   = {{32{A[31]}}, A};
      b_sx   = {{32{B[31]}}, B};
      prod_s = a_sx * b_sx;
      prod_u = {32'd0, A} * {32'd0, B};
      b_zero = (B == 32'd0);

      // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 rem 0
      // without relying on overflow behaviour of the '/' operator.
      abs_a    = A[31] ? (~A + 32'd1) : A;
      abs_b    = B[31] ? (~B + 32'd1) : B;
      // Divisor forced non-zero so the unused divide-by-zero result stays defined
      sdiv_dvs = b_zero ? 32'd1 : abs_b;
      q_mag    = abs_a / sdiv_dvs;
      r_mag    = abs_a % sdiv_dvs;
      sdiv_q   = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
      sdiv_r   = A[31] ? (~r_mag + 32'd1) : r_mag;

      udiv_dvs = b_zero ? 32'd1 : B;
      udiv_q   = A / udiv_dvs;
      udiv_r   = A % udiv_dvs;

      is_multi = (md_op == OpMult) || (md_op == OpMultu) ||
                 (md_op == OpDiv)  || (md_op == OpDivu);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= 32'd0;
         pend_q    <= 64'd0;
         pend_dz_q <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  case (md_op)
                     OpMult: begin
                        pend_q    <= prod_s;
                        pend_dz_q <= 1'b0;
                        cnt_q     <= 32'(MULT_CYCLES);
                        state_q   <= StRun;
                     end
                     OpMultu: begin
                        pend_q    <= prod_u;
                        pend_dz_q <= 1'b0;
                        cnt_q     <= 32'(MULT_CYCLES);
                        state_q   <= StRun;
                     end
                     OpDiv: begin
                        pend_q    <= {sdiv_r, sdiv_q};
                        pend_dz_q <= b_zero;
                        cnt_q     <= 32'(DIV_CYCLES);
                        state_q   <= StRun;
                     end
                     OpDivu: begin
                        pend_q    <= {udiv_r, udiv_q};
                        pend_dz_q <= b_zero;
                        cnt_q     <= 32'(DIV_CYCLES);
                        state_q   <= StRun;
                     end
                     OpMthi:  hi_q <= A;
                     OpMtlo:  lo_q <= A;
                     default: ;
                  endcase
               end
            end
            StRun: begin
               // start/md_op are ignored here; the pipeline holds them back
               cnt_q <= cnt_q - 32'd1;
               if (cnt_q == 32'd1) begin
                  if (!pend_dz_q) begin
                     hi_q <= pend_q[63:32];
                     lo_q <= pend_q[31:0];
                  end
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy      = (state_q == StRun);
   assign md_active = busy | (start & is_multi);
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit. Completion results go through a queue that a
// negedge monitor drains whenever busy falls. Single-cycle ops and reset are checked inline.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] A, B;
   logic        busy, md_active;
   logic [31:0] hi, lo;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .md_op     (md_op),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .md_active (md_active),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: measures each busy run and compares hi/lo when it ends
   int   run_len   = 0;
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         run_len   = 0;
         prev_busy = 1'b0;
      end else begin
         if (busy) run_len++;
         if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_completion", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("busy_cycles", 64'(run_len), 64'(e.cycles));
               check("hi", {32'd0, hi}, {32'd0, e.hi});
               check("lo", {32'd0, lo}, {32'd0, e.lo});
            end
            run_len = 0;
         end
         prev_busy = busy;
      end
   end

   // Present an op for one edge (called at posedge+1), check md_active before the edge
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic exp_active);
      start = 1'b1;
      md_op = op;
      A     = a;
      B     = b;
      #1;
      check("md_active", {63'd0, md_active}, {63'd0, exp_active});
      @(posedge clk);
      #1;
      start = 1'b0;
      md_op = 3'b000;
   endtask

   task automatic push(input logic [31:0] h, input logic [31:0] l, input int n);
      exp_t e;
      e.hi     = h;
      e.lo     = l;
      e.cycles = n;
      exp_q.push_back(e);
   endtask

   // Leaves us in the first non-busy cycle (posedge+1)
   task automatic wait_idle();
      int k = 0;
      while (busy && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (busy) check("wait_idle_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      logic clean;
      reset = 1'b1;
      start = 1'b0;
      md_op = 3'b000;
      A     = 32'd0;
      B     = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_md_active", {63'd0, md_active}, 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // mult / multu, second multu back-to-back in the first non-busy cycle
      push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
      issue(3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
      check("busy_after_accept", {63'd0, busy}, 64'd1);
      wait_idle();
      push(32'h0000_0002, 32'hFFFF_FFFA, 5);
      issue(3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
      wait_idle();
      push(32'h0000_0001, 32'h0000_0000, 5);
      issue(3'b010, 32'h0001_0000, 32'h0001_0000, 1'b1);
      wait_idle();
      push(32'h4000_0000, 32'h0000_0000, 5);
      issue(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b1);
      wait_idle();

      // Divides
      push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      issue(3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
      wait_idle();
      push(32'h0000_0001, 32'h0000_0003, 10);
      issue(3'b100, 32'h0000_0007, 32'h0000_0002, 1'b1);
      wait_idle();
      push(32'h0000_0000, 32'h8000_0000, 10);
      issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_idle();
      push(32'h0000_0001, 32'hFFFF_FFFD, 10);
      issue(3'b011, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1);
      wait_idle();

      // Divide by zero keeps the previous hi/lo
      issue(3'b101, 32'h1234_5678, 32'd0, 1'b0);
      issue(3'b110, 32'h9ABC_DEF0, 32'd0, 1'b0);
      push(32'h1234_5678, 32'h9ABC_DEF0, 10);
      issue(3'b100, 32'h0000_0005, 32'h0000_0000, 1'b1);
      wait_idle();

      // mthi then mtlo in consecutive cycles
      issue(3'b101, 32'hDEAD_BEEF, 32'd0, 1'b0);
      check("mthi_hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
      check("mthi_busy", {63'd0, busy}, 64'd0);
      issue(3'b110, 32'h0BAD_F00D, 32'd0, 1'b0);
      check("mtlo_lo", {32'd0, lo}, {32'd0, 32'h0BAD_F00D});
      check("mtlo_busy", {63'd0, busy}, 64'd0);

      // mtlo during a div is ignored: 100 / 7 = 14 rem 2
      push(32'h0000_0002, 32'h0000_000E, 10);
      issue(3'b011, 32'd100, 32'd7, 1'b1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      issue(3'b110, 32'h1111_1111, 32'd0, 1'b1);
      check("ignored_mtlo", {32'd0, lo}, {32'd0, 32'h0BAD_F00D});
      wait_idle();

      // Reset in cycle 2 of a mult aborts it
      issue(3'b001, 32'd5, 32'd6, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_hilo", {hi, lo}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      clean = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (busy || hi != 32'd0 || lo != 32'd0) clean = 1'b0;
      end
      check("no_stale_result", {63'd0, clean}, 64'd1);

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
